// File: rtl/store_checker.sv
// End-of-test detector on the data-memory write port: sticky PASS/FAIL verdict, counters, last-store capture.
// Optional cycle watchdog is built when STORE_CHECKER_WATCHDOG_EN is defined.
module store_checker #(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  fail_code,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count,
    output logic [31:0] last_addr,
    output logic [31:0] last_data
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PASS = 2'd1,
        S_FAIL = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_ILLEGAL = 2'd1;
    localparam logic [1:0] CODE_BADDATA = 2'd2;

`ifdef STORE_CHECKER_WATCHDOG_EN
    localparam logic [1:0]  CODE_TIMEOUT = 2'd3;
    localparam logic [31:0] WD_LAST      = 32'(TIMEOUT_CYCLES - 1);
`endif

    state_t      state_q, state_d;
    logic [1:0]  code_q, code_d;
    logic [15:0] store_q, store_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] laddr_q, laddr_d;
    logic [31:0] ldata_q, ldata_d;
    logic        done_q, pass_q, fail_q;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        store_d = store_q;
        cycle_d = cycle_q;
        laddr_d = laddr_q;
        ldata_d = ldata_q;
        if (state_q == S_RUN) begin
            if (cycle_q != '1) cycle_d = cycle_q + 32'd1;
            if (MemWrite) begin
                if (store_q != '1) store_d = store_q + 16'd1;
                laddr_d = DataAdr;
                ldata_d = WriteData;
                // Equality-true tests only, so an unknown address/data bit falls to a failing branch.
                if (DataAdr == PASS_ADDR && WriteData == PASS_DATA) begin
                    state_d = S_PASS;
                end else if (DataAdr == PASS_ADDR) begin
                    state_d = S_FAIL;
                    code_d  = CODE_BADDATA;
                end else if (DataAdr == SCRATCH_ADDR) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_FAIL;
                    code_d  = CODE_ILLEGAL;
                end
            end
`ifdef STORE_CHECKER_WATCHDOG_EN
            // A terminal store in the expiry cycle takes precedence over the timeout.
            if (state_d == S_RUN && cycle_q == WD_LAST) begin
                state_d = S_FAIL;
                code_d  = CODE_TIMEOUT;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            code_q  <= CODE_NONE;
            store_q <= '0;
            cycle_q <= '0;
            laddr_q <= '0;
            ldata_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            store_q <= store_d;
            cycle_q <= cycle_d;
            laddr_q <= laddr_d;
            ldata_q <= ldata_d;
            done_q  <= (state_d != S_RUN);
            pass_q  <= (state_d == S_PASS);
            fail_q  <= (state_d == S_FAIL);
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = code_q;
    assign store_count = store_q;
    assign cycle_count = cycle_q;
    assign last_addr   = laddr_q;
    assign last_data   = ldata_q;

endmodule

// File: tb/tb_store_checker.sv
// Self-checking bench for store_checker: vector table plus watchdog/expiry sequences, scoreboard queue.
module tb_store_checker;

`ifdef STORE_CHECKER_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        done, pass, fail;
    logic [1:0]  fail_code;
    logic [15:0] store_count;
    logic [31:0] cycle_count, last_addr, last_data;

    store_checker #(
        .PASS_ADDR     (32'd100),
        .PASS_DATA     (32'd25),
        .SCRATCH_ADDR  (32'd96),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .fail_code  (fail_code),
        .store_count(store_count),
        .cycle_count(cycle_count),
        .last_addr  (last_addr),
        .last_data  (last_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        done;
        logic        pass;
        logic        fail;
        logic [1:0]  code;
        logic [15:0] sc;
        logic [31:0] cc;
        logic [31:0] la;
        logic [31:0] ld;
    } out_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        out_t        exp;
    } vec_t;

    out_t q_exp[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic out_t o_run(input int sc, input int cc, input int la, input int ld);
        return '{1'b0, 1'b0, 1'b0, 2'd0, 16'(sc), 32'(cc), 32'(la), 32'(ld)};
    endfunction
    function automatic out_t o_pass(input int sc, input int cc, input int la, input int ld);
        return '{1'b1, 1'b1, 1'b0, 2'd0, 16'(sc), 32'(cc), 32'(la), 32'(ld)};
    endfunction
    function automatic out_t o_fail(input int code, input int sc, input int cc, input int la, input int ld);
        return '{1'b1, 1'b0, 1'b1, 2'(code), 16'(sc), 32'(cc), 32'(la), 32'(ld)};
    endfunction

    task automatic step(input string name, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input out_t e);
        out_t act, exp;
        @(negedge clk);
        reset = r; MemWrite = w; DataAdr = a; WriteData = d;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        act = '{done, pass, fail, fail_code, store_count, cycle_count, last_addr, last_data};
        exp = q_exp.pop_front();
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got done=%b pass=%b fail=%b code=%0d sc=%0d cc=%0d la=%0d ld=%0d, expected done=%b pass=%b fail=%b code=%0d sc=%0d cc=%0d la=%0d ld=%0d",
                     name, act.done, act.pass, act.fail, act.code, act.sc, act.cc, act.la, act.ld,
                     exp.done, exp.pass, exp.fail, exp.code, exp.sc, exp.cc, exp.la, exp.ld);
        else
            n_pass++;
    endtask

    vec_t tbl[16];

    initial begin
        // rst, we, addr, data, expected outputs after the edge
        tbl[0]  = '{1, 0,   0,  0, o_run(0, 0, 0, 0)};
        tbl[1]  = '{0, 1,  96,  7, o_run(1, 1, 96, 7)};
        tbl[2]  = '{0, 1,  96, 18, o_run(2, 2, 96, 18)};
        tbl[3]  = '{0, 1, 100, 25, o_pass(3, 3, 100, 25)};
        tbl[4]  = '{0, 1, 104,  0, o_pass(3, 3, 100, 25)};
        tbl[5]  = '{1, 1, 104,  0, o_run(0, 0, 0, 0)};
        tbl[6]  = '{0, 0,   0,  0, o_run(0, 1, 0, 0)};
        tbl[7]  = '{1, 0,   0,  0, o_run(0, 0, 0, 0)};
        tbl[8]  = '{0, 1, 100, 24, o_fail(2, 1, 1, 100, 24)};
        tbl[9]  = '{0, 1, 100, 25, o_fail(2, 1, 1, 100, 24)};
        tbl[10] = '{1, 0,   0,  0, o_run(0, 0, 0, 0)};
        tbl[11] = '{0, 1, 104, 25, o_fail(1, 1, 1, 104, 25)};
        tbl[12] = '{1, 0,   0,  0, o_run(0, 0, 0, 0)};
        tbl[13] = '{0, 0,  96,  9, o_run(0, 1, 0, 0)};
        tbl[14] = '{0, 1,  96,  5, o_run(1, 2, 96, 5)};
        tbl[15] = '{0, 1, 101, 25, o_fail(1, 2, 3, 101, 25)};

        for (int i = 0; i < 16; i++)
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].exp);

        // Idle run: watchdog expiry at cycle 20 (when built), else keeps counting to 40.
        step("wd_reset", 1, 0, 0, 0, o_run(0, 0, 0, 0));
        for (int k = 1; k <= 40; k++) begin
            if (WD && k >= 20)
                step($sformatf("wd_idle%0d", k), 0, 0, 0, 0, o_fail(3, 0, 20, 0, 0));
            else
                step($sformatf("wd_idle%0d", k), 0, 0, 0, 0, o_run(0, k, 0, 0));
        end

        // Pass signature in the expiry cycle beats the timeout.
        step("exp_pass_reset", 1, 0, 0, 0, o_run(0, 0, 0, 0));
        for (int k = 1; k <= 19; k++)
            step($sformatf("exp_pass_idle%0d", k), 0, 0, 0, 0, o_run(0, k, 0, 0));
        step("exp_pass_store", 0, 1, 100, 25, o_pass(1, 20, 100, 25));
        step("exp_pass_hold", 0, 1, 96, 3, o_pass(1, 20, 100, 25));

        // Scratch store in the expiry cycle is still counted but does not prevent the timeout.
        step("exp_scr_reset", 1, 0, 0, 0, o_run(0, 0, 0, 0));
        for (int k = 1; k <= 19; k++)
            step($sformatf("exp_scr_idle%0d", k), 0, 0, 0, 0, o_run(0, k, 0, 0));
        if (WD)
            step("exp_scr_store", 0, 1, 96, 42, o_fail(3, 1, 20, 96, 42));
        else
            step("exp_scr_store", 0, 1, 96, 42, o_run(1, 20, 96, 42));

        // Reset after a verdict with a concurrent illegal store discards the store.
        step("post_reset", 1, 1, 104, 0, o_run(0, 0, 0, 0));
        step("post_run", 0, 1, 96, 1, o_run(1, 1, 96, 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
